// File: rtl/spi_xfer_sched_pkg.sv
// -----------------------------------------------------------------------------
// spi_xfer_sched_pkg
// Shared definitions for the SPI transfer scheduler:
//   - SPI word width and default idle-gap / timeout constants
//   - scheduler state encoding (3-bit)
//   - id_onehot(): index to one-hot helper used to build the ack vector
// No ports (package).
// -----------------------------------------------------------------------------
package spi_xfer_sched_pkg;

  localparam int SPI_M   = 16;
  localparam int DEF_GAP = 2;
  localparam int DEF_TMO = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // One-hot decode of a requester index (up to 8 requesters).
  function automatic logic [7:0] id_onehot(input logic [2:0] id);
    return 8'd1 << id;
  endfunction

endpackage

// File: rtl/spi_xfer_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// spi_xfer_sched_rr_arbiter
// Purely combinational round-robin arbiter. Searches req starting at ptr+1
// upward with wrap-around and returns the first requester found.
// Ports:
//   req     in  N  request vector
//   ptr     in  3  index of the most recently served requester (must be < N)
//   gnt_id  out 3  granted requester index (0 when nothing requested)
//   gnt_vld out 1  at least one request is pending
// -----------------------------------------------------------------------------
module spi_xfer_sched_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [2:0]   gnt_id,
  output logic         gnt_vld
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] sh;
  logic [N-1:0]   rot;
  int             s;

  // Rotate req so that bit 0 is requester ptr+1, then pick the lowest set bit.
  always_comb begin
    dbl     = {req, req};
    sh      = dbl >> (32'(ptr) + 1);
    rot     = sh[N-1:0];
    gnt_vld = |rot;
    gnt_id  = 3'd0;
    s       = 0;
    // Walk from the far end down so the nearest candidate is assigned last.
    for (int j = N - 1; j >= 0; j--) begin
      s      = 32'(ptr) + 1 + j;
      s      = (s >= N) ? (s - N) : s;
      gnt_id = rot[j] ? 3'(s) : gnt_id;
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// -----------------------------------------------------------------------------
// spi_xfer_sched
// Round-robin scheduler sharing one SPI master among N requesters. For each
// frame it grants a requester, issues a one-cycle start with the TX word, waits
// for the master's end-of-frame load strobe, returns the RX word with a
// one-cycle one-hot ack, then idles GAP cycles before the next grant.
//
// Optional feature macro: SPI_XFER_SCHED_TMO_EN
//   defined   : frames not finished within TMO cycles of WAIT complete with
//               rx_dat=0 and err=1 alongside the ack.
//   undefined : WAIT is unbounded, err is constant 0.
//
// Ports:
//   clk      in  1    system clock (rising edge)
//   RESET    in  1    synchronous active-low reset
//   req      in  N    per-requester request level
//   tx_dat   in  N*M  TX words, requester i at [i*M +: M]
//   ack      out N    one-hot completion pulse
//   rx_dat   out M    received word, held until the next ack
//   err      out 1    timeout flag, pulses with ack
//   busy     out 1    high from grant until the end of the idle gap
//   cur_id   out 3    current / last granted requester
//   st       out 1    start pulse to the SPI master
//   mtx_dat  out M    TX word to the SPI master
//   load     in  1    end-of-frame strobe from the SPI master
//   mrx_dat  in  M    RX word from the SPI master, valid with load
// -----------------------------------------------------------------------------
module spi_xfer_sched
  import spi_xfer_sched_pkg::*;
#(
  parameter int N   = 4,
  parameter int M   = SPI_M,
  parameter int GAP = DEF_GAP,
  parameter int TMO = DEF_TMO
) (
  input  logic           clk,
  input  logic           RESET,
  input  logic [N-1:0]   req,
  input  logic [N*M-1:0] tx_dat,
  output logic [N-1:0]   ack,
  output logic [M-1:0]   rx_dat,
  output logic           err,
  output logic           busy,
  output logic [2:0]     cur_id,
  output logic           st,
  output logic [M-1:0]   mtx_dat,
  input  logic           load,
  input  logic [M-1:0]   mrx_dat
);

  // One counter serves both the idle gap and the frame timeout.
  localparam int             CW       = $clog2(TMO + 256) + 1;
  localparam logic [CW-1:0]  GAP_LAST = CW'(GAP - 1);
`ifdef SPI_XFER_SCHED_TMO_EN
  localparam logic [CW-1:0]  TMO_LAST = CW'(TMO - 1);
`endif

  state_e         state, nxt_state;
  logic [2:0]     ptr, nxt_ptr;
  logic [CW-1:0]  cnt, nxt_cnt;
  logic [N-1:0]   nxt_ack;
  logic [M-1:0]   nxt_rx, nxt_mtx, tx_sel;
  logic           nxt_err, nxt_busy, nxt_st;
  logic [2:0]     nxt_cur_id;
  logic [2:0]     gnt_id;
  logic           gnt_vld;

  spi_xfer_sched_rr_arbiter #(.N(N)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  // Select the TX word of the requester the arbiter is about to grant.
  always_comb begin
    tx_sel = '0;
    for (int i = 0; i < N; i++) begin
      tx_sel = (gnt_id == 3'(i)) ? tx_dat[i*M +: M] : tx_sel;
    end
  end

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    nxt_state  = state;
    nxt_ptr    = ptr;
    nxt_cnt    = cnt;
    nxt_ack    = '0;
    nxt_err    = 1'b0;
    nxt_st     = 1'b0;
    nxt_busy   = busy;
    nxt_cur_id = cur_id;
    nxt_mtx    = mtx_dat;
    nxt_rx     = rx_dat;
    case (state)
      ST_IDLE: begin
        if (gnt_vld) begin
          nxt_state  = ST_START;
          nxt_cur_id = gnt_id;
          nxt_mtx    = tx_sel;
          nxt_busy   = 1'b1;
          nxt_st     = 1'b1;
        end else begin
          nxt_state  = ST_IDLE;
        end
      end
      ST_START: begin
        // load is ignored here: the master cannot finish in zero cycles.
        nxt_state = ST_WAIT;
        nxt_cnt   = '0;
      end
      ST_WAIT: begin
        if (load) begin
          nxt_rx    = mrx_dat;
          nxt_ack   = N'(id_onehot(cur_id));
          nxt_state = ST_DONE;
        end else begin
`ifdef SPI_XFER_SCHED_TMO_EN
          if (cnt == TMO_LAST) begin
            nxt_rx    = '0;
            nxt_err   = 1'b1;
            nxt_ack   = N'(id_onehot(cur_id));
            nxt_state = ST_DONE;
          end else begin
            nxt_cnt   = cnt + CW'(1);
          end
`else
          nxt_state = ST_WAIT;
`endif
        end
      end
      ST_DONE: begin
        // ack is high during this state; the winner becomes lowest priority.
        nxt_ptr = cur_id;
        nxt_cnt = '0;
        if (GAP == 0) begin
          nxt_state = ST_IDLE;
          nxt_busy  = 1'b0;
        end else begin
          nxt_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          nxt_state = ST_IDLE;
          nxt_busy  = 1'b0;
        end else begin
          nxt_cnt   = cnt + CW'(1);
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_busy  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      ptr     <= 3'(N - 1);
      cnt     <= '0;
      ack     <= '0;
      err     <= 1'b0;
      st      <= 1'b0;
      busy    <= 1'b0;
      cur_id  <= 3'd0;
      mtx_dat <= '0;
      rx_dat  <= '0;
    end else begin
      state   <= nxt_state;
      ptr     <= nxt_ptr;
      cnt     <= nxt_cnt;
      ack     <= nxt_ack;
      err     <= nxt_err;
      st      <= nxt_st;
      busy    <= nxt_busy;
      cur_id  <= nxt_cur_id;
      mtx_dat <= nxt_mtx;
      rx_dat  <= nxt_rx;
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_sched
// Self-checking bench for spi_xfer_sched (N=4, M=16, GAP=2). A behavioural
// SPI master answers each start with load after a fixed latency, returning the
// nibble-reversed TX word. Expected acks are queued when stimulus is driven and
// compared when the scheduler acks. Define SPI_XFER_SCHED_TMO_EN to also run
// the timeout scenario (TMO=16).
// -----------------------------------------------------------------------------
module tb_spi_xfer_sched;

  localparam int N    = 4;
  localparam int M    = 16;
  localparam int GAP  = 2;
  localparam int MLAT = 4;
`ifdef SPI_XFER_SCHED_TMO_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1024;
`endif

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] rx;
    logic        er;
  } exp_t;

  logic           clk = 1'b0;
  logic           RESET;
  logic [N-1:0]   req;
  logic [N*M-1:0] tx_dat;
  logic [N-1:0]   ack;
  logic [M-1:0]   rx_dat;
  logic           err;
  logic           busy;
  logic [2:0]     cur_id;
  logic           st;
  logic [M-1:0]   mtx_dat;
  logic           load;
  logic [M-1:0]   mrx_dat;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          load_cyc = -1;
  int          last_ack_cyc = -1;
  int          ack_total = 0;
  int          st_total = 0;
  bit          gap_chk = 1'b0;
  bit          mdl_en = 1'b1;
  logic [15:0] txw [N];

  spi_xfer_sched #(.N(N), .M(M), .GAP(GAP), .TMO(TB_TMO)) dut (
    .clk     (clk),
    .RESET   (RESET),
    .req     (req),
    .tx_dat  (tx_dat),
    .ack     (ack),
    .rx_dat  (rx_dat),
    .err     (err),
    .busy    (busy),
    .cur_id  (cur_id),
    .st      (st),
    .mtx_dat (mtx_dat),
    .load    (load),
    .mrx_dat (mrx_dat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rev_nib(input logic [15:0] w);
    return {w[3:0], w[7:4], w[11:8], w[15:12]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [15:0] rx, input logic er);
    exp_t e;
    e.id = 3'(id);
    e.rx = rx;
    e.er = er;
    sb.push_back(e);
  endtask

  // Wait for n acks (bounded); optionally drop the acked requester's req.
  task automatic wait_acks(input int n, input bit drop);
    int seen = 0;
    int t = 0;
    while (seen < n && t < 400) begin
      @(negedge clk);
      t++;
      if (ack != '0) begin
        seen++;
        if (drop) req = req & ~ack;
      end
    end
    if (seen < n) chk("ack_timeout", 32'(seen), 32'(n));
  endtask

  task automatic wait_st();
    int t = 0;
    @(negedge clk);
    while (!st && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!st) chk("st_timeout", 32'(st), 32'(1));
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (st) begin
      st_total++;
      if (gap_chk && last_ack_cyc >= 0) chk("gap", 32'(cyc - last_ack_cyc), 32'(GAP + 2));
    end
    if (ack != '0) begin
      ack_total++;
      last_ack_cyc = cyc;
      chk("ack_vs_st", 32'(st), 32'(0));
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack", 32'(ack), 32'(1) << e.id);
        chk("rx_dat", 32'(rx_dat), 32'(e.rx));
        chk("err", 32'(err), 32'(e.er));
        if (!e.er) chk("ack_lat", 32'(cyc - load_cyc), 32'(1));
      end
    end
  end

  // Behavioural SPI master: load MLAT cycles after start, unless reset.
  initial begin
    logic [15:0] cap;
    bit          aborted;
    load    = 1'b0;
    mrx_dat = '0;
    forever begin
      @(negedge clk);
      if (st && mdl_en) begin
        cap     = mtx_dat;
        aborted = 1'b0;
        for (int k = 0; k < MLAT; k++) begin
          @(negedge clk);
          if (!RESET) aborted = 1'b1;
        end
        if (!aborted) begin
          chk("mtx_hold", 32'(mtx_dat), 32'(cap));
          load     = 1'b1;
          mrx_dat  = rev_nib(cap);
          load_cyc = cyc;
          @(negedge clk);
          load     = 1'b0;
          mrx_dat  = '0;
        end
      end
    end
  end

  initial begin
    int snap;
    int ts;
    txw[0] = 16'h1234;
    txw[1] = 16'hA5C3;
    txw[2] = 16'hBEEF;
    txw[3] = 16'h0F0F;
    tx_dat = {txw[3], txw[2], txw[1], txw[0]};
    req    = '0;
    RESET  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_st", 32'(st), 32'(0));
    chk("rst_mtx", 32'(mtx_dat), 32'(0));
    chk("rst_rx", 32'(rx_dat), 32'(0));
    chk("rst_cur_id", 32'(cur_id), 32'(0));
    RESET = 1'b1;
    repeat (2) @(negedge clk);

    // Round-robin with all requesters active: 0,1,2,3,0
    gap_chk      = 1'b1;
    last_ack_cyc = -1;
    for (int i = 0; i < 5; i++) push_exp(i % N, rev_nib(txw[i % N]), 1'b0);
    req = 4'b1111;
    wait_acks(5, 1'b0);
    req     = '0;
    gap_chk = 1'b0;
    repeat (6) @(negedge clk);

    // Single request from requester 1
    push_exp(1, 16'h3C5A, 1'b0);
    req = 4'b0010;
    @(negedge clk);
    chk("single_st", 32'(st), 32'(1));
    chk("single_mtx", 32'(mtx_dat), 32'(16'hA5C3));
    chk("single_cur_id", 32'(cur_id), 32'(1));
    chk("single_busy", 32'(busy), 32'(1));
    wait_acks(1, 1'b1);
    chk("busy_at_ack", 32'(busy), 32'(1));
    repeat (GAP) @(negedge clk);
    chk("busy_in_gap", 32'(busy), 32'(1));
    @(negedge clk);
    chk("busy_after_gap", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);

    // Serve 2, then a simultaneous 0 and 2: 0 wins, then 2
    push_exp(2, rev_nib(txw[2]), 1'b0);
    req = 4'b0100;
    wait_acks(1, 1'b1);
    repeat (5) @(negedge clk);
    push_exp(0, rev_nib(txw[0]), 1'b0);
    push_exp(2, rev_nib(txw[2]), 1'b0);
    req = 4'b0101;
    wait_acks(2, 1'b1);
    repeat (5) @(negedge clk);

    // load while idle is ignored
    snap = ack_total;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_load", 32'(ack_total - snap), 32'(0));

    // Requester 3 drops req mid-frame: frame completes, no re-grant
    push_exp(3, rev_nib(txw[3]), 1'b0);
    req = 4'b1000;
    wait_st();
    @(negedge clk);
    req  = '0;
    snap = st_total;
    wait_acks(1, 1'b0);
    repeat (10) @(negedge clk);
    chk("no_regrant", 32'(st_total - snap), 32'(0));

    // Reset during WAIT: everything clears, no ack
    req = 4'b0100;
    wait_st();
    @(negedge clk);
    RESET = 1'b0;
    snap  = ack_total;
    @(negedge clk);
    chk("mrst_ack", 32'(ack), 32'(0));
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_st", 32'(st), 32'(0));
    chk("mrst_mtx", 32'(mtx_dat), 32'(0));
    chk("mrst_rx", 32'(rx_dat), 32'(0));
    chk("mrst_cur_id", 32'(cur_id), 32'(0));
    req = '0;
    @(negedge clk);
    RESET = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst_no_ack", 32'(ack_total - snap), 32'(0));
    push_exp(3, rev_nib(txw[3]), 1'b0);
    req = 4'b1000;
    @(negedge clk);
    chk("post_rst_cur_id", 32'(cur_id), 32'(3));
    wait_acks(1, 1'b1);
    repeat (5) @(negedge clk);
    // ptr is 3 (= N-1): requester 0 wins the tie against 3
    push_exp(0, rev_nib(txw[0]), 1'b0);
    push_exp(3, rev_nib(txw[3]), 1'b0);
    req = 4'b1001;
    wait_acks(2, 1'b1);
    repeat (5) @(negedge clk);

`ifdef SPI_XFER_SCHED_TMO_EN
    // Timeout: master never answers
    mdl_en = 1'b0;
    push_exp(0, 16'h0000, 1'b1);
    req = 4'b0001;
    wait_st();
    ts = cyc;
    wait_acks(1, 1'b1);
    chk("tmo_lat", 32'(cyc - ts), 32'(TB_TMO + 1));
    snap = ack_total;
    @(negedge clk);
    load    = 1'b1;
    mrx_dat = 16'hFFFF;
    @(negedge clk);
    load    = 1'b0;
    mrx_dat = '0;
    repeat (6) @(negedge clk);
    chk("late_load", 32'(ack_total - snap), 32'(0));
    mdl_en = 1'b1;
`else
    ts = 0;
    chk("err_tied", 32'(err), 32'(ts));
`endif

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
